// File: rtl/reset_domain_sequencer.sv
// reset_domain_sequencer: holds N_DOMAINS register banks in reset, then releases
// them one at a time in index order, raising each bank's write enable STAGE_CYCLES
// after its reset falls. The next active bank is released on the same edge that
// enables the previous one. Software can re-reset any subset of banks while idle.
// Optional build macro RESET_SEQ_COUNT_EN enables the saturating seq_count counter;
// without it seq_count is tied to zero.
module reset_domain_sequencer #(
  parameter int N_DOMAINS    = 4,
  parameter int HOLD_CYCLES  = 8,
  parameter int STAGE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  input  logic [N_DOMAINS-1:0] req_mask,
  output logic                 req_ready,
  output logic                 ack,
  output logic                 busy,
  output logic [N_DOMAINS-1:0] dom_rst,
  output logic [N_DOMAINS-1:0] dom_en,
  output logic [7:0]           seq_count
);

  localparam int CNT_MAX = (HOLD_CYCLES > STAGE_CYCLES) ? HOLD_CYCLES : STAGE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  // idx must reach N_DOMAINS: that value marks "all banks walked, leave next cycle".
  localparam int IDX_W   = $clog2(N_DOMAINS + 1);

  if (N_DOMAINS < 1 || N_DOMAINS > 16) begin : g_bad_n
    $error("N_DOMAINS must be in 1..16");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("HOLD_CYCLES must be >= 1");
  end
  if (STAGE_CYCLES < 1) begin : g_bad_stage
    $error("STAGE_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_RELEASE = 2'd1,
    S_IDLE    = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [N_DOMAINS-1:0] active_mask_q, active_mask_d;
  logic                 soft_q, soft_d;
  logic                 ack_q, ack_d;
  logic [N_DOMAINS-1:0] dom_rst_q, dom_rst_d;
  logic [N_DOMAINS-1:0] dom_en_q, dom_en_d;

  logic [N_DOMAINS-1:0] cur_oh, nxt_oh;
  logic                 cur_active, nxt_active;

  // One-hot views of the current and following bank, so bank selection needs no
  // variable bit index (idx_q == N_DOMAINS yields an all-zero cur_oh).
  always_comb begin
    for (int i = 0; i < N_DOMAINS; i++) begin
      cur_oh[i] = (idx_q == IDX_W'(i));
    end
    nxt_oh     = cur_oh << 1;
    cur_active = |(cur_oh & active_mask_q);
    nxt_active = |(nxt_oh & active_mask_q);
  end

  // Next-state and output logic for the hold / release / idle sequence.
  always_comb begin
    // NOTE: every signal gets its default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    active_mask_d = active_mask_q;
    soft_d        = soft_q;
    ack_d         = 1'b0;
    dom_rst_d     = dom_rst_q;
    dom_en_d      = dom_en_q;

    unique case (state_q)
      S_HOLD: begin
        if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
          state_d = S_RELEASE;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_RELEASE: begin
        if (idx_q == IDX_W'(N_DOMAINS)) begin
          state_d = S_IDLE;
          if (soft_q) begin
            ack_d  = 1'b1;
            soft_d = 1'b0;
          end
        end else if (cur_active && cnt_q == '0) begin
          // First bank of a walk (or one reached from idle): release its reset.
          dom_rst_d = dom_rst_q & ~cur_oh;
          cnt_d     = CNT_W'(1);
        end else if (cur_active && cnt_q != CNT_W'(STAGE_CYCLES)) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          // Enable a settled bank, or skip an inactive one; either way move on and
          // release the following active bank on this same edge.
          if (cur_active) begin
            dom_en_d = dom_en_q | cur_oh;
          end
          idx_d = idx_q + 1'b1;
          cnt_d = '0;
          if (nxt_active) begin
            dom_rst_d = dom_rst_d & ~nxt_oh;
            cnt_d     = CNT_W'(1);
          end
        end
      end

      S_IDLE: begin
        if (req_valid) begin
          if (|req_mask) begin
            state_d       = S_HOLD;
            cnt_d         = '0;
            idx_d         = '0;
            active_mask_d = req_mask;
            soft_d        = 1'b1;
            dom_rst_d     = dom_rst_q | req_mask;
            dom_en_d      = dom_en_q & ~req_mask;
          end else begin
            ack_d = 1'b1;
          end
        end
      end

      default: state_d = S_HOLD;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst) begin
      state_q       <= S_HOLD;
      cnt_q         <= '0;
      idx_q         <= '0;
      active_mask_q <= '1;
      soft_q        <= 1'b0;
      ack_q         <= 1'b0;
      dom_rst_q     <= '1;
      dom_en_q      <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      active_mask_q <= active_mask_d;
      soft_q        <= soft_d;
      ack_q         <= ack_d;
      dom_rst_q     <= dom_rst_d;
      dom_en_q      <= dom_en_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign req_ready = (state_q == S_IDLE);
  assign ack       = ack_q;
  assign dom_rst   = dom_rst_q;
  assign dom_en    = dom_en_q;

`ifdef RESET_SEQ_COUNT_EN
  logic [7:0] seq_count_q, seq_count_d;
  logic       seq_done;

  // A nonzero-mask software sequence completes on the cycle that enters idle.
  assign seq_done = (state_q == S_RELEASE) && (idx_q == IDX_W'(N_DOMAINS)) && soft_q;

  // Saturating completion counter.
  always_comb begin
    seq_count_d = seq_count_q;
    if (seq_done && seq_count_q != 8'hFF) begin
      seq_count_d = seq_count_q + 8'd1;
    end
  end

  // Counter register, cleared only by rst.
  always_ff @(posedge clk) begin
    if (!rst) begin
      seq_count_q <= 8'h00;
    end else begin
      seq_count_q <= seq_count_d;
    end
  end

  assign seq_count = seq_count_q;
`else
  assign seq_count = 8'h00;
`endif

endmodule

// File: tb/tb_reset_domain_sequencer.sv
// Directed bench for reset_domain_sequencer with default parameters. Cycle c
// denotes the value seen just after edge c-1, edge 0 being the first edge with rst=1.
module tb_reset_domain_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid = 1'b0;
  logic [3:0] req_mask = 4'b0000;
  logic       req_ready, ack, busy;
  logic [3:0] dom_rst, dom_en;
  logic [7:0] seq_count;

  int checks = 0;
  int errors = 0;

  reset_domain_sequencer #(
    .N_DOMAINS   (4),
    .HOLD_CYCLES (8),
    .STAGE_CYCLES(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_mask (req_mask),
    .req_ready(req_ready),
    .ack      (ack),
    .busy     (busy),
    .dom_rst  (dom_rst),
    .dom_en   (dom_en),
    .seq_count(seq_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // {dom_rst, dom_en, busy, req_ready, ack}
  typedef struct {
    int         cyc;
    logic [3:0] r;
    logic [3:0] e;
    logic       b;
    logic       rd;
    logic       a;
  } vec_t;

  vec_t        vecs [18];
  logic [10:0] obs  [0:63];

  function automatic logic [10:0] snap();
    return {dom_rst, dom_en, busy, req_ready, ack};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         ack_cnt;
    logic [7:0] exp_seq;
    bit         done;

    // Power-up followed by a request held from the start (mask 0101, taken at cycle 26).
    vecs[0]  = '{1,  4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{8,  4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{9,  4'b1110, 4'b0000, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{12, 4'b1110, 4'b0000, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{13, 4'b1100, 4'b0001, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{17, 4'b1000, 4'b0011, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{21, 4'b0000, 4'b0111, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{25, 4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{26, 4'b0000, 4'b1111, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{27, 4'b0101, 4'b1010, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{35, 4'b0101, 4'b1010, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{36, 4'b0100, 4'b1010, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{40, 4'b0100, 4'b1011, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{41, 4'b0000, 4'b1011, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{45, 4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{46, 4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0};
    vecs[16] = '{47, 4'b0000, 4'b1111, 1'b0, 1'b1, 1'b1};
    vecs[17] = '{48, 4'b0000, 4'b1111, 1'b0, 1'b1, 1'b0};

`ifdef RESET_SEQ_COUNT_EN
    exp_seq = 8'd1;
`else
    exp_seq = 8'd0;
`endif

    // Reset state.
    repeat (3) tick();
    check("reset_outputs", 32'(snap()), 32'({4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0}));
    check("reset_seq_count", 32'(seq_count), 32'd0);

    // Release rst with a request already pending.
    rst       = 1'b1;
    req_valid = 1'b1;
    req_mask  = 4'b0101;
    for (int k = 0; k < 48; k++) begin
      tick();
      obs[k+1] = snap();
      check($sformatf("en_implies_not_rst_c%0d", k + 1), 32'(dom_en & dom_rst), 32'd0);
      if (k + 1 == 27) req_valid = 1'b0;
    end

    foreach (vecs[i]) begin
      check($sformatf("seq_c%0d", vecs[i].cyc), 32'(obs[vecs[i].cyc]),
            32'({vecs[i].r, vecs[i].e, vecs[i].b, vecs[i].rd, vecs[i].a}));
    end

    ack_cnt = 0;
    for (int c = 1; c <= 46; c++) ack_cnt += int'(obs[c][0]);
    check("no_ack_before_soft_done", 32'(ack_cnt), 32'd0);
    check("seq_count_after_soft", 32'(seq_count), 32'(exp_seq));

    // Zero-mask request: ack only, banks untouched.
    req_valid = 1'b1;
    req_mask  = 4'b0000;
    tick();
    req_valid = 1'b0;
    check("zero_mask_ack", 32'(snap()), 32'({4'b0000, 4'b1111, 1'b0, 1'b1, 1'b1}));
    tick();
    check("zero_mask_ack_once", 32'(snap()), 32'({4'b0000, 4'b1111, 1'b0, 1'b1, 1'b0}));
    check("zero_mask_seq_count", 32'(seq_count), 32'(exp_seq));

    // rst asserted mid-way through a software sequence.
    req_valid = 1'b1;
    req_mask  = 4'b0011;
    tick();
    req_valid = 1'b0;
    repeat (14) tick();
    rst = 1'b0;
    tick();
    check("mid_rst_outputs", 32'(snap()), 32'({4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0}));
    check("mid_rst_seq_count", 32'(seq_count), 32'd0);
    rst = 1'b1;
    ack_cnt = 0;
    done    = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      tick();
      ack_cnt += int'(ack);
      if (!busy) done = 1'b1;
    end
    check("repowerup_done_in_time", 32'(done), 32'd1);
    check("repowerup_no_ack", 32'(ack_cnt), 32'd0);
    check("repowerup_all_enabled", 32'({dom_rst, dom_en}), 32'({4'b0000, 4'b1111}));

`ifdef RESET_SEQ_COUNT_EN
    // Back-to-back single-bank requests drive the counter into saturation.
    for (int n = 0; n < 260; n++) begin
      logic [3:0] m;
      m         = 4'b0001 << (n % 4);
      req_valid = 1'b1;
      req_mask  = m;
      tick();
      req_valid = 1'b0;
      done = 1'b0;
      for (int c = 0; c < 60 && !done; c++) begin
        tick();
        if (ack) done = 1'b1;
      end
      if (!done) begin
        check($sformatf("sat_ack_timeout_n%0d", n), 32'(done), 32'd1);
        break;
      end
      if (n == 253) check("seq_count_254", 32'(seq_count), 32'd254);
    end
    check("seq_count_saturated", 32'(seq_count), 32'd255);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reset_domain_sequencer.md
Name: reset_domain_sequencer

Overview:
- Controller that sequences reset assertion and deassertion for up to N_DOMAINS banks of asynchronously-reset registers.
- Holds every bank in reset for a minimum time, then releases banks one at a time in index order.
- Raises each bank's write enable only after its reset has been released and stable for STAGE_CYCLES, so reset deassertion never coincides with a write.
- Sits between the chip reset/clock logic and the register banks; also accepts a software re-reset request for any subset of banks.

Parameters:
- N_DOMAINS, 4: number of controlled register banks (1..16).
- HOLD_CYCLES, 8: cycles the reset is held asserted before the first release (>=1; elaboration error otherwise).
- STAGE_CYCLES, 4: cycles between a bank's reset release and its enable, and therefore before the next bank's release (>=1; elaboration error otherwise).

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-low reset.
- req_valid  in  1  software re-reset request.
- req_mask  in  N_DOMAINS  banks to re-reset; sampled when req_valid && req_ready.
- req_ready  out  1  sequencer idle; a request can be accepted.
- ack  out  1  one-cycle pulse when a software request completes.
- busy  out  1  sequence in progress.
- dom_rst  out  N_DOMAINS  active-high reset to each bank; registered output.
- dom_en  out  N_DOMAINS  write enable to each bank; registered output.
- seq_count  out  8  completed software sequences; see Optional Feature.

Behaviour:
- Reset (rst=0, sampled on clk):
  - state=HOLD, active_mask=all ones, cnt=0, idx=0.
  - dom_rst=all ones, dom_en=0, busy=1, req_ready=0, ack=0, seq_count=0.
  - The soft flag is cleared.
- rst=0 in any state, mid-sequence included, returns to these values on the next edge.
- Invariant: dom_en[i]=1 implies dom_rst[i]=0.
- HOLD state:
  - cnt increments each cycle.
  - When cnt==HOLD_CYCLES-1: go to RELEASE, cnt=0, idx=0.
- RELEASE state, per idx:
  - If active_mask[idx]=0: advance idx in 1 cycle; no outputs change.
  - Otherwise: dom_rst[idx] falls on the first cycle, then wait STAGE_CYCLES cycles.
  - Then dom_en[idx] rises and idx advances.
  - The next active bank's dom_rst falls in the same cycle as the previous bank's dom_en rises.
- Leaving RELEASE:
  - After idx==N_DOMAINS-1 completes, go to IDLE.
  - If soft flag is set: ack=1 for exactly 1 cycle on IDLE entry, seq_count increments, soft flag clears.
- IDLE state:
  - busy=0, req_ready=1.
  - Unmasked dom_rst/dom_en are never modified by any request.
- Request acceptance (req_valid && req_ready):
  - Nonzero mask: next cycle active_mask=req_mask; dom_rst[i]=1 and dom_en[i]=0 for masked i; soft flag set; state=HOLD; busy=1; req_ready=0.
  - req_mask==0: no state change, ack pulses next cycle, seq_count unchanged.
- req_valid while busy: ignored; no queuing.
- Power-up sequence produces no ack.
- Timing with defaults, cycle 0 = first edge with rst=1:
  - dom_rst[0] low from cycle 9.
  - dom_en[0] and dom_rst[1] change at 13.
  - dom_en[3] high at 25.
  - busy=0 at 26.
- Width rule: cnt sized to clog2(max(HOLD_CYCLES, STAGE_CYCLES)+1).

Optional Feature:
- Macro: RESET_SEQ_COUNT_EN.
- Defined: seq_count is an 8-bit counter of completed nonzero-mask software sequences. It saturates at 255 and never wraps. It is cleared only by rst.
- Undefined: seq_count is tied to 8'h00 and no counter logic is built. The port is always present.

Test Plan:
- Power-up, defaults: release rst at cycle 0 -> dom_rst falls 4'b1110 at 9, 4'b1100 at 13, 4'b1000 at 17, 4'b0000 at 21; dom_en reaches 4'b1111 at 25; busy=0 at 26; ack never pulses.
- Idle, req_mask=4'b0101 accepted at cycle T -> dom_rst=4'b0101, dom_en=4'b1010 at T+1; bank 1 and bank 3 untouched; bank 0 released at T+10, bank 2 at T+15 (idx1 skip costs 1 cycle); single ack; seq_count=1 when RESET_SEQ_COUNT_EN is defined, else 0.
- req_valid held high during power-up sequence -> req_ready=0; request not taken until busy=0, then accepted on first idle cycle.
- req_mask=0 accepted -> ack 1 cycle later, dom_rst and dom_en unchanged, seq_count unchanged.
- rst=0 at cycle 15 of a software sequence -> next edge dom_rst=4'b1111, dom_en=0, seq_count=0, no ack.
- RESET_SEQ_COUNT_EN defined, 260 back-to-back single-bank requests -> seq_count stops at 255.
